hazard_scoreboard: RTL
======================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter NUM_REGS, default 32, architectural register count (x0 hardwired zero).
REQ-002 SHALL have parameter REG_W, default 5, register-address width, equal to clog2(NUM_REGS).
REQ-003 SHALL have parameter LOAD_LAT, default 1, range 1..7, cycles after issue during which a load destination is unforwardable.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port issue_valid  in  1  valid ID instruction presented for ID->EX advance.
REQ-007 SHALL have port issue_rd  in  REG_W  destination of the ID instruction.
REQ-008 SHALL have port issue_class  in  2  write class of the ID instruction: 0 none, 1 ALU, 2 LOAD, 3 MULDIV.
REQ-009 SHALL have ports rs1_ID, rs2_ID  in  REG_W each  ID source register fields.
REQ-010 SHALL have ports pc_rs1_sel, imm_rs2_sel  in  1 each  field is a true register source when 0.
REQ-011 SHALL have port flush  in  1  ID instruction squashed this cycle (EX branch redirect).
REQ-012 SHALL have ports muldiv_done  in  1 and muldiv_rd  in  REG_W  multi-cycle unit result forwardable this cycle.
REQ-013 SHALL have port stall  out  1  hold PC/IF-ID and insert bubble into ID-EX.
REQ-014 SHALL have port busy_vec  out  NUM_REGS  bit r set when register r has any pending hazard.

Function
REQ-015 SHALL keep one countdown counter cnt[r] (3 bits) per register r = 1..NUM_REGS-1.
REQ-016 SHALL keep one multi-cycle tracker: md_busy (1 bit) and md_rd (REG_W).
REQ-017 SHALL define "accept" as issue_valid & !stall & !flush.
REQ-018 On accept with class LOAD and issue_rd != 0, SHALL load cnt[issue_rd] = LOAD_LAT at the clock edge.
REQ-019 On accept with class MULDIV and issue_rd != 0, SHALL set md_busy = 1 and md_rd = issue_rd.
REQ-020 Classes NONE and ALU SHALL leave counters unchanged (forwarding covers them).
REQ-021 Every nonzero cnt[r] not being reloaded SHALL decrement by 1 per cycle; on reload the reload wins.
REQ-022 On muldiv_done with md_busy & (muldiv_rd == md_rd), SHALL clear md_busy; a non-matching done SHALL be ignored.
REQ-023 pend(r) SHALL be (r != 0) & (cnt[r] != 0 | (md_busy & md_rd == r & !(muldiv_done & muldiv_rd == r))).
REQ-024 stall SHALL be combinational and asserted when issue_valid & !flush & any of:
  - RAW: (!pc_rs1_sel & pend(rs1_ID)) | (!imm_rs2_sel & pend(rs2_ID))
  - structural: class MULDIV & md_busy & !(muldiv_done & muldiv_rd == md_rd)
  - WAW: class != NONE & issue_rd != 0 & md_busy & md_rd == issue_rd & !muldiv_done
REQ-025 flush SHALL force stall = 0 and block every scoreboard set that cycle; decrements and done-clears continue.
REQ-026 busy_vec[r] SHALL equal pend(r); busy_vec[0] SHALL be 0.
REQ-027 With LOAD_LAT = 1 and no MULDIV traffic, stall SHALL match classic load-use: one bubble for a dependent instruction directly behind a load, none at distance 2.
REQ-028 Register x0 SHALL never be tracked and never cause stall.

Reset
REQ-029 rst high SHALL asynchronously clear all cnt[r], md_busy and md_rd to 0.
REQ-030 During and after reset, stall and busy_vec SHALL be 0 until a new accept; in-flight hazards before reset are discarded.

Structure
REQ-031 Write-class encoding (enum NONE/ALU/LOAD/MULDIV) SHALL reside in the shared pipeline package, reused by decode.
REQ-032 SHALL instantiate one sub-module, hazard_reg_counter (one 3-bit countdown with load/decrement), generated per register 1..NUM_REGS-1.

Verification
REQ-033 LOAD x5 accepted, then next cycle ID uses rs1=x5 -> stall=1 for exactly 1 cycle; with LOAD_LAT=3 -> 3 cycles.
REQ-034 MULDIV x7 accepted, dependent ADD rs2=x7 waits; muldiv_done with rd=7 in cycle 6 -> stall=1 cycles 1-5, 0 in cycle 6.
REQ-035 MULDIV x7 pending, second MULDIV x9 -> stall until done for x7; done and issue in same cycle -> accepted, md_rd=9.
REQ-036 LOAD x0 then use of x0, and imm_rs2_sel=1 with rs2=x5 behind load x5 -> stall=0 both cases.
REQ-037 Dependent use behind LOAD x5 with flush=1 -> stall=0, no scoreboard change; ALU x7 while MULDIV x7 pending -> WAW stall.
REQ-038 rst asserted mid-MULDIV with cnt[3]=2 -> busy_vec=0 and stall=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared pipeline definitions: instruction write classes and scoreboard sizing.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hazard_scoreboard_pkg;

    // Write class of an instruction, as produced by decode.
    typedef enum logic [1:0] {
        WC_NONE   = 2'd0,
        WC_ALU    = 2'd1,
        WC_LOAD   = 2'd2,
        WC_MULDIV = 2'd3
    } wclass_e;

    // Width of each per-register load countdown (LOAD_LAT is at most 7).
    localparam int CNT_W = 3;

endpackage

// File: rtl/hazard_scoreboard_counter.sv
// Per-register load countdown: reload on i_load, otherwise count down to zero.
// Latency: o_cnt reflects a reload or decrement one clock after the edge.
// Backpressure: none; reload has priority over decrement.
//
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   i_load      - reload the counter with i_load_val this edge
//   i_load_val  - reload value
//   o_cnt       - current count (nonzero = destination not yet forwardable)
module hazard_reg_counter
    import hazard_scoreboard_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: load countdowns plus one multi-cycle unit tracker.
// Latency: stall/busy_vec are combinational; scoreboard updates at the next edge.
// Backpressure: stall holds PC/IF-ID and bubbles ID-EX; flush overrides stall.
//
// Ports:
//   clk, rst                    - clock, asynchronous active-high reset
//   issue_valid/rd/class        - ID instruction offered for ID->EX advance
//   rs1_ID, rs2_ID              - ID source fields
//   pc_rs1_sel, imm_rs2_sel     - field is a real register source only when 0
//   flush                       - ID instruction squashed this cycle
//   muldiv_done, muldiv_rd      - multi-cycle result forwardable this cycle
//   stall                       - hazard detected for the ID instruction
//   busy_vec                    - per-register pending-hazard flags
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int REG_W    = 5,
    parameter int LOAD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                issue_valid,
    input  logic [REG_W-1:0]    issue_rd,
    input  logic [1:0]          issue_class,
    input  logic [REG_W-1:0]    rs1_ID,
    input  logic [REG_W-1:0]    rs2_ID,
    input  logic                pc_rs1_sel,
    input  logic                imm_rs2_sel,
    input  logic                flush,
    input  logic                muldiv_done,
    input  logic [REG_W-1:0]    muldiv_rd,
    output logic                stall,
    output logic [NUM_REGS-1:0] busy_vec
);

    localparam logic [CNT_W-1:0] LOAD_CNT = CNT_W'(LOAD_LAT);

    wclass_e             w_class;
    logic                w_rd_nz;
    logic                w_accept;
    logic                w_md_done_match;
    logic                w_raw;
    logic                w_struct;
    logic                w_waw;
    logic                w_stall;
    logic [NUM_REGS-1:0] w_pend;

    logic                r_md_busy;
    logic [REG_W-1:0]    r_md_rd;

    assign w_class  = wclass_e'(issue_class);
    assign w_rd_nz  = (issue_rd != '0);
    assign w_accept = issue_valid & ~w_stall & ~flush;

    // Completion of the tracked multi-cycle op; its result forwards this cycle.
    assign w_md_done_match = muldiv_done & (muldiv_rd == r_md_rd);

    // x0 is never tracked.
    assign w_pend[0] = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
        logic [CNT_W-1:0] w_cnt;
        logic             w_load;

        assign w_load = w_accept & (w_class == WC_LOAD) & (issue_rd == REG_W'(r));

        hazard_reg_counter u_cnt (
            .clk        (clk),
            .rst        (rst),
            .i_load     (w_load),
            .i_load_val (LOAD_CNT),
            .o_cnt      (w_cnt)
        );

        // A MULDIV destination stops being a hazard in the cycle its result
        // appears on the forwarding path.
        assign w_pend[r] = (w_cnt != '0)
                         | (r_md_busy & (r_md_rd == REG_W'(r))
                            & ~(muldiv_done & (muldiv_rd == REG_W'(r))));
    end

    assign w_raw    = (~pc_rs1_sel  & w_pend[rs1_ID])
                    | (~imm_rs2_sel & w_pend[rs2_ID]);
    // Only one multi-cycle op can be outstanding; a new one may issue in the
    // cycle the old one completes.
    assign w_struct = (w_class == WC_MULDIV) & r_md_busy & ~w_md_done_match;
    // Any result retiring from the unit this cycle is treated as clearing WAW.
    assign w_waw    = (w_class != WC_NONE) & w_rd_nz & r_md_busy
                    & (r_md_rd == issue_rd) & ~muldiv_done;

    assign w_stall  = issue_valid & ~flush & (w_raw | w_struct | w_waw);

    // New issue wins over a same-cycle completion so the new op stays tracked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_md_busy <= 1'b0;
            r_md_rd   <= '0;
        end else if (w_accept & (w_class == WC_MULDIV) & w_rd_nz) begin
            r_md_busy <= 1'b1;
            r_md_rd   <= issue_rd;
        end else if (r_md_busy & w_md_done_match) begin
            r_md_busy <= 1'b0;
        end
    end

    assign stall    = w_stall;
    assign busy_vec = w_pend;

endmodule
